// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit ALU stage: widths, op codes, FSM states and
// the signed-overflow rule used by ADD/SUB/SLT.
package alu_pkg;

    localparam int WIDTH    = 32;
    localparam int MUL_ITER = WIDTH;
    localparam int CNT_W    = $clog2(MUL_ITER);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Overflow when both addends share a sign and the sum's sign differs.
    // For subtraction the caller passes the sign of the inverted B operand.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/mul32_shift_add.sv
// Unsigned 32x32 shift-add multiplier: one partial-product add per cycle,
// 32 iterations, 64-bit product. done/prod present the final value on the
// completing edge so the caller can register it without an extra cycle.
module mul32_shift_add
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH:0]     partial;
    logic               last;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // this block leaves one unassigned (which would infer a latch).
        a_d     = a_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_sh_q[0] ? {1'b0, a_q} : '0);
        last    = busy_q && (cnt_q == CNT_LAST);

        if (load && !busy_q) begin
            a_d    = a;
            b_sh_d = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // The 33-bit sum keeps the carry, which becomes the new MSB after the shift.
            acc_d  = {partial, acc_q[WIDTH-1:1]};
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        // NOTE: the datapath registers are reset too, because a reset must leave
        // the product and counter cleared, not just the control bit.
        if (!rst_n) begin
            a_q    <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_sh_q <= b_sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = last;
    assign prod = acc_d;

endmodule

// File: rtl/alu32_seq_unit.sv
// 32-bit ALU stage: single-cycle logic/add/sub/slt ops and a multi-cycle
// multiply, with registered result, flags and a one-cycle done pulse.
module alu32_seq_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              zero,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum;
    logic               add_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    logic               mul_load;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    mul32_shift_add u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mul_load),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // One adder serves ADD, SUB and SLT; SUB/SLT use a + ~b + 1.
    always_comb begin
        b_eff   = (op == OP_ADD) ? b : ~b;
        sum     = a + b_eff + {{(WIDTH-1){1'b0}}, (op != OP_ADD)};
        add_ovf = signed_ovf(a[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        mul_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        ovf_d       = alu_ovf;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately not looked at here, including on the completing edge.
                if (mul_done) begin
                    result_d    = mul_prod[WIDTH-1:0];
                    result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_prod[WIDTH-1:0] == '0);
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign busy      = mul_busy;
    assign done      = done_q;

endmodule
